// File: rtl/sram_ctrl.sv
// Single-request initiator for a 1K x 8 asynchronous SRAM: setup, access, hold phases.
// Define SRAM_CTRL_WRITE_VERIFY_EN to add a read-back check (VRFY phase) after writes.
module sram_ctrl #(
    parameter int ACC_CYCLES = 2,
    parameter int AW         = 10,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_wr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          sram_cs,
    output logic          sram_wr,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, VRFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
`endif

    localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic          op_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_wr_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          sram_cs_q;
    logic          sram_wr_q;
    logic [AW-1:0] sram_addr_q;
    logic [DW-1:0] sram_din_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    logic          rsp_err_q;
`endif

    assign cnt_d = cnt_q + 4'd1;

    // sram_addr_q/sram_din_q double as the latched request address and write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            sram_cs_q   <= 1'b0;
            sram_wr_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        op_q        <= req_wr;
                        sram_wr_q   <= req_wr;
                        sram_addr_q <= req_addr;
                        sram_din_q  <= req_wdata;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q     <= 4'd0;
                    sram_cs_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        if (!op_q) begin
                            rsp_rdata_q <= sram_dout;
                        end
                        sram_cs_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= op_q;
                        state_q     <= HOLD;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
                        // Writes stay selected and turn into a read-back of the same address.
                        if (op_q) begin
                            sram_cs_q   <= 1'b1;
                            sram_wr_q   <= 1'b0;
                            rsp_valid_q <= 1'b0;
                            cnt_q       <= 4'd0;
                            state_q     <= VRFY;
                        end
`endif
                    end
                end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
                VRFY: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        rsp_err_q   <= (sram_dout != sram_din_q);
                        sram_cs_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= op_q;
                        state_q     <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    sram_wr_q   <= 1'b0;
                    req_ready_q <= 1'b1;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sram_cs   = sram_cs_q;
    assign sram_wr   = sram_wr_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Synchronous initiator for the 1K x 8 asynchronous SRAM (chip-select, write-enable, 10-bit address, separate 8-bit data in/out).
- Accepts single read/write requests from a host over a valid/ready handshake.
- Sequences SRAM control pins through setup, access and hold phases, then returns read data and a completion pulse.
- Sits between system logic and the SRAM macro. It is the only driver of the SRAM pins.

Parameters:
ACC_CYCLES, 2, cycles sram_cs is held high per access (legal range 1..15)
AW, 10, SRAM address width
DW, 8, SRAM data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request valid
req_ready  output  1  controller can accept request
req_wr  input  1  1 = write, 0 = read
req_addr  input  AW  request address
req_wdata  input  DW  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_wr  output  1  op type of completed request
rsp_rdata  output  DW  read data (valid with rsp_valid on reads)
rsp_err  output  1  write-verify mismatch (see Optional Feature)
sram_cs  output  1  SRAM chip select, active high
sram_wr  output  1  SRAM write enable, 1 = write
sram_addr  output  AW  SRAM address
sram_din  output  DW  data to SRAM data_in
sram_dout  input  DW  data from SRAM data_out

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including sram_cs, sram_wr, sram_addr, sram_din and rsp_rdata.
  - An in-flight access is abandoned, with no rsp_valid.
  - req_ready=1 from the first clock after rst_n deasserts.
- All outputs are registered or decoded from registered state. Nothing is combinational from inputs.
- States: IDLE, SETUP, ACCESS, HOLD (plus VRFY when the feature is enabled).
- IDLE:
  - req_ready=1, sram_cs=0.
  - On req_valid&&req_ready: latch req_wr, req_addr and req_wdata, then go to SETUP.
  - The request is held until completion; host inputs are ignored until the next IDLE.
- SETUP (1 cycle):
  - sram_addr and sram_din are driven from the latched values.
  - sram_wr = latched op, sram_cs=0.
  - Next state: ACCESS, with cnt loaded to 0.
- ACCESS (ACC_CYCLES cycles):
  - sram_cs=1; addr, din and wr are stable.
  - cnt increments each cycle.
  - On the edge ending the last cycle (cnt==ACC_CYCLES-1): on a read, capture sram_dout into rsp_rdata, then go to HOLD.
- HOLD (1 cycle):
  - sram_cs=0; addr, din and wr remain stable (hold time).
  - rsp_valid=1, rsp_wr = latched op.
  - rsp_rdata is unchanged on writes (keeps last read value).
  - Next state: IDLE.
- Latency: acceptance edge to rsp_valid is ACC_CYCLES+2 cycles. Throughput is one request per ACC_CYCLES+3 cycles.
- req_ready=0 in every state except IDLE. A req_valid asserted while busy is not consumed and must be held by the host.
- sram_wr never changes while sram_cs=1. sram_addr never changes while sram_cs=1.
- sram_wr returns to 0 in IDLE.
- cnt is 4 bits wide and saturates at neither end; it is reloaded in SETUP.

Optional Feature:
Macro: SRAM_CTRL_WRITE_VERIFY_EN
- Defined:
  - After the ACCESS phase of a write, go to VRFY instead of HOLD.
  - VRFY lasts ACC_CYCLES cycles: sram_cs=1, sram_wr=0, same address.
  - At the last VRFY cycle, compare sram_dout to the latched wdata. On mismatch, rsp_err=1, sent together with rsp_valid in HOLD.
  - Write latency becomes 2*ACC_CYCLES+2. Read timing is unchanged.
  - rsp_err is 0 on reads and cleared in IDLE.
- Not defined:
  - No VRFY state exists.
  - rsp_err is tied to 0.

Test Plan:
- Write then read: write 0xFC to addr 0x030, then read 0x030 -> rsp_valid after 4 cycles each (ACC_CYCLES=2), rsp_rdata=0xFC, rsp_wr=0 on the read.
- Read of unwritten addr 0x03C (model preloaded 0x00) -> rsp_rdata=0x00. sram_cs is high exactly 2 cycles, sram_addr=0x03C stable from SETUP through HOLD.
- Back-to-back: req_valid held high with 3 requests -> req_ready high only in IDLE, each request accepted 5 cycles apart, 3 rsp_valid pulses in order.
- Reset mid-op: assert rst_n=0 during ACCESS of a write to 0x155 -> sram_cs, sram_wr and all outputs 0 without waiting for clk, no rsp_valid, next request completes normally.
- ACC_CYCLES=1 and 15 boundary: sram_cs pulse width equals ACC_CYCLES, and latency equals ACC_CYCLES+2.
- With SRAM_CTRL_WRITE_VERIFY_EN: write 0xA5 to 0x3FF with the SRAM model forcing bit0 stuck at 0 -> rsp_err=1 with rsp_valid. Clean write gives rsp_err=0, and latency is 6 cycles at ACC_CYCLES=2.
